debug_unit: RTL and testbench

UART-driven debug controller upstream of the MIPS pipeline. Decodes single-byte host commands to:
- load a program into instruction memory;
- reset the PC;
- run to halt or single-step by gating the pipeline clock enable.

After every run or step it dumps the 32-entry register file and a window of data memory back to the host. It sits between the UART rx/tx byte interfaces and the pipeline's `dunit` ports.

---
 rtl/debug_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_debug_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit
//   Byte-command debug controller that sits between a UART rx/tx pair and the
//   MIPS pipeline's debug ports. Host commands:
//     'L' (0x4C) load program words (4 bytes each, MSB first) into instruction
//                memory until HALT_WORD or memory is full; also resets the PC
//     'C' (0x43) run the pipeline until i_halt, then dump
//     'S' (0x53) run the pipeline for one cycle, then dump
//     'R' (0x52) pulse the PC reset
//   A dump sends the 32 register-file words followed by NB_DMEM_WORDS
//   data-memory words, each MSB first.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_rx_data/i_rx_done   received byte and its one-cycle valid pulse
//   o_tx_data/o_tx_start  byte to send and its one-cycle start pulse
//   i_tx_done             one-cycle pulse, previous byte sent
//   o_dunit_clk_en        pipeline clock enable
//   o_dunit_reset_pc      one-cycle PC reset pulse
//   o_dunit_w_mem         instruction-memory write strobe
//   o_dunit_mem_addr      instruction-memory byte address
//   o_dunit_data_if       instruction-memory write data
//   o_dunit_addr          register-file read address
//   i_dunit_reg           register-file read data
//   o_dunit_addr_data     data-memory read byte address
//   i_dunit_mem_data      data-memory read data
//   i_halt                halt instruction reached WB
//   o_state               current state encoding (LEDs)

module debug_unit #(
    parameter int unsigned        NB_REG        = 32,
    parameter int unsigned        NB_ADDR       = 5,
    parameter int unsigned        NB_WIDHT      = 9,
    parameter int unsigned        NB_DMEM_WORDS = 32,
    parameter int unsigned        NB_IMEM_WORDS = 128,
    parameter logic [NB_REG-1:0]  HALT_WORD     = 32'hFFFF_FFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_done,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_reset_pc,
    output logic                o_dunit_w_mem,
    output logic [NB_REG-1:0]   o_dunit_mem_addr,
    output logic [NB_REG-1:0]   o_dunit_data_if,
    output logic [NB_ADDR-1:0]  o_dunit_addr,
    input  logic [NB_REG-1:0]   i_dunit_reg,
    output logic [NB_WIDHT-1:0] o_dunit_addr_data,
    input  logic [NB_REG-1:0]   i_dunit_mem_data,
    input  logic                i_halt,
    output logic [3:0]          o_state
);

    localparam int unsigned N_ITEMS = 32 + NB_DMEM_WORDS;
    localparam int unsigned ITEM_W  = $clog2(N_ITEMS);
    localparam int unsigned WIDX_W  = $clog2(NB_IMEM_WORDS);

    localparam logic [ITEM_W-1:0] LAST_ITEM      = ITEM_W'(N_ITEMS - 1);
    localparam logic [ITEM_W-1:0] FIRST_MEM_ITEM = ITEM_W'(32);
    localparam logic [WIDX_W-1:0] LAST_WIDX      = WIDX_W'(NB_IMEM_WORDS - 1);

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_RSTPC = 8'h52;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        LOAD_BYTE   = 4'd1,
        LOAD_WRITE  = 4'd2,
        RUN         = 4'd3,
        STEP        = 4'd4,
        DUMP_ADDR   = 4'd5,
        DUMP_WAIT   = 4'd6,
        DUMP_SEND   = 4'd7,
        DUMP_TXWAIT = 4'd8
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NB_REG-1:0]   shift;
    logic [1:0]          byte_cnt;
    logic [WIDX_W-1:0]   word_idx;
    logic [ITEM_W-1:0]   item;
    logic                reset_pc_q;
    logic                item_is_mem;
    logic [ITEM_W-1:0]   mem_item;

    assign item_is_mem = (item >= FIRST_MEM_ITEM);
    assign mem_item    = item - FIRST_MEM_ITEM;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: state_next = LOAD_BYTE;
                        CMD_CONT: state_next = RUN;
                        CMD_STEP: state_next = STEP;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            LOAD_BYTE: begin
                if (i_rx_done && byte_cnt == 2'd3) begin
                    state_next = LOAD_WRITE;
                end
            end
            LOAD_WRITE: begin
                // The halt word itself is written before the load ends.
                if (shift == HALT_WORD || word_idx == LAST_WIDX) begin
                    state_next = IDLE;
                end else begin
                    state_next = LOAD_BYTE;
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_next = DUMP_ADDR;
                end
            end
            STEP:      state_next = DUMP_ADDR;
            DUMP_ADDR: state_next = DUMP_WAIT;
            DUMP_WAIT: state_next = DUMP_SEND;
            DUMP_SEND: state_next = DUMP_TXWAIT;
            DUMP_TXWAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt != 2'd3) begin
                        state_next = DUMP_SEND;
                    end else if (item == LAST_ITEM) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DUMP_ADDR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift register is shared between load assembly and dump
    // serialisation; byte_cnt counts bytes within the current word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift      <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            item       <= '0;
            reset_pc_q <= 1'b0;
        end else begin
            reset_pc_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_LOAD) begin
                            shift      <= '0;
                            byte_cnt   <= '0;
                            word_idx   <= '0;
                            reset_pc_q <= 1'b1;
                        end else if (i_rx_data == CMD_RSTPC) begin
                            reset_pc_q <= 1'b1;
                        end
                    end
                end
                LOAD_BYTE: begin
                    if (i_rx_done) begin
                        shift    <= {shift[NB_REG-9:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                LOAD_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_cnt <= '0;
                end
                DUMP_WAIT: begin
                    shift    <= item_is_mem ? i_dunit_mem_data : i_dunit_reg;
                    byte_cnt <= '0;
                end
                DUMP_TXWAIT: begin
                    if (i_tx_done) begin
                        shift    <= {shift[NB_REG-9:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            item <= (item == LAST_ITEM) ? '0 : item + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_dunit_clk_en    = 1'b0;
        o_dunit_w_mem     = 1'b0;
        o_dunit_mem_addr  = '0;
        o_dunit_data_if   = '0;
        o_tx_start        = 1'b0;
        o_tx_data         = '0;
        o_dunit_reset_pc  = reset_pc_q;
        o_state           = state;
        // Address outputs follow the item index so they stay stable for the
        // whole item; the register address parks at its last value once the
        // data-memory items begin.
        o_dunit_addr      = item_is_mem ? '1 : NB_ADDR'(item);
        o_dunit_addr_data = item_is_mem ? NB_WIDHT'({mem_item, 2'b00}) : '0;

        case (state)
            RUN, STEP: o_dunit_clk_en = !i_halt;
            LOAD_WRITE: begin
                o_dunit_w_mem    = 1'b1;
                o_dunit_mem_addr = NB_REG'({word_idx, 2'b00});
                o_dunit_data_if  = shift;
            end
            DUMP_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = shift[NB_REG-1 -: 8];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_debug_unit.sv
module tb_debug_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_dunit_clk_en;
    logic        o_dunit_reset_pc;
    logic        o_dunit_w_mem;
    logic [31:0] o_dunit_mem_addr;
    logic [31:0] o_dunit_data_if;
    logic [4:0]  o_dunit_addr;
    logic [31:0] i_dunit_reg;
    logic [8:0]  o_dunit_addr_data;
    logic [31:0] i_dunit_mem_data;
    logic        i_halt;
    logic [3:0]  o_state;

    always #5 clk = ~clk;

    debug_unit #(
        .NB_REG        (32),
        .NB_ADDR       (5),
        .NB_WIDHT      (9),
        .NB_DMEM_WORDS (32),
        .NB_IMEM_WORDS (128),
        .HALT_WORD     (32'hFFFF_FFFF)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_rx_data         (i_rx_data),
        .i_rx_done         (i_rx_done),
        .o_tx_data         (o_tx_data),
        .o_tx_start        (o_tx_start),
        .i_tx_done         (i_tx_done),
        .o_dunit_clk_en    (o_dunit_clk_en),
        .o_dunit_reset_pc  (o_dunit_reset_pc),
        .o_dunit_w_mem     (o_dunit_w_mem),
        .o_dunit_mem_addr  (o_dunit_mem_addr),
        .o_dunit_data_if   (o_dunit_data_if),
        .o_dunit_addr      (o_dunit_addr),
        .i_dunit_reg       (i_dunit_reg),
        .o_dunit_addr_data (o_dunit_addr_data),
        .i_dunit_mem_data  (i_dunit_mem_data),
        .i_halt            (i_halt),
        .o_state           (o_state)
    );

    // Pipeline model: register file and data memory, read combinationally.
    logic [31:0] regs [32];
    logic [31:0] dmem [32];
    assign i_dunit_reg      = regs[o_dunit_addr];
    assign i_dunit_mem_data = dmem[o_dunit_addr_data[6:2]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0] exp_tx [$];
    wr_t        exp_wr [$];
    logic [7:0] exp_byte;
    wr_t        exp_w;

    int checks = 0;
    int errors = 0;
    int clk_en_cnt = 0;
    int rpc_cnt = 0;
    int wr_cnt = 0;
    int tx_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tx_start) begin
                tx_cnt++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: unexpected byte %02h, none expected", o_tx_data);
                end else begin
                    exp_byte = exp_tx.pop_front();
                    if (o_tx_data !== exp_byte) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, expected %02h", o_tx_data, exp_byte);
                    end
                end
            end
            if (o_dunit_w_mem) begin
                wr_cnt++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL imem_write: unexpected write addr %0h data %0h",
                             o_dunit_mem_addr, o_dunit_data_if);
                end else begin
                    exp_w = exp_wr.pop_front();
                    if (o_dunit_mem_addr !== exp_w.addr || o_dunit_data_if !== exp_w.data) begin
                        errors++;
                        $display("FAIL imem_write: got addr %0h data %0h, expected addr %0h data %0h",
                                 o_dunit_mem_addr, o_dunit_data_if, exp_w.addr, exp_w.data);
                    end
                end
            end
            if (o_dunit_clk_en)   clk_en_cnt++;
            if (o_dunit_reset_pc) rpc_cnt++;
        end
    end

    // UART tx model: sometimes a stray tx_done in the tx_start cycle (must be
    // ignored), then the real tx_done after a random delay.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            if (rst_n === 1'b1 && o_tx_start === 1'b1) begin
                i_tx_done = ($urandom_range(0, 1) == 1);
                @(posedge clk); #1;
                i_tx_done = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                i_tx_done = 1'b1;
                @(posedge clk); #1;
                i_tx_done = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_rx(w[8*b +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump();
        for (int k = 0; k < 32; k++) push_word(regs[k]);
        for (int j = 0; j < 32; j++) push_word(dmem[j]);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) begin
            regs[k] = $urandom;
            dmem[k] = $urandom;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!(o_state == 4'd0 && exp_tx.size() == 0 && exp_wr.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: state %0d, %0d bytes and %0d writes outstanding, expected none",
                     name, o_state, exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] cmd_free_word();
        logic [31:0] w;
        logic [7:0]  b;
        for (int i = 0; i < 4; i++) begin
            do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h52 || b == 8'hFF);
            w[8*i +: 8] = b;
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rpc0, wr0, tx0, n;
        logic [31:0] w;
        logic [31:0] words [$];

        rst_n     = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_halt    = 1'b0;
        for (int k = 0; k < 32; k++) begin
            regs[k] = 32'(k);
            dmem[k] = 32'hA000_0000 | 32'(k * 4);
        end

        // Reset state
        #2;
        check("reset_tx_start", 32'(o_tx_start), 0);
        check("reset_clk_en", 32'(o_dunit_clk_en), 0);
        check("reset_reset_pc", 32'(o_dunit_reset_pc), 0);
        check("reset_w_mem", 32'(o_dunit_w_mem), 0);
        check("reset_state", 32'(o_state), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 'R': one-cycle PC reset, stays idle
        rpc0 = rpc_cnt;
        send_rx(8'h52);
        @(negedge clk);
        check("r_reset_pc_high", 32'(o_dunit_reset_pc), 1);
        @(negedge clk);
        check("r_reset_pc_low", 32'(o_dunit_reset_pc), 0);
        check("r_state_idle", 32'(o_state), 0);
        check("r_pulse_count", 32'(rpc_cnt - rpc0), 1);

        // Load: two words ending with the halt word
        rpc0 = rpc_cnt;
        exp_wr.push_back('{32'h0, 32'h2008_0005});
        exp_wr.push_back('{32'h4, 32'hFFFF_FFFF});
        send_rx(8'h4C);
        send_word(32'h2008_0005);
        send_word(32'hFFFF_FFFF);
        wait_done("load", 200);
        check("load_reset_pc_pulses", 32'(rpc_cnt - rpc0), 1);
        check("load_state_idle", 32'(o_state), 0);

        // Step with the reference register/memory pattern
        push_dump();
        clk_en_cnt = 0;
        send_rx(8'h53);
        @(negedge clk);
        check("step_clk_en_first", 32'(o_dunit_clk_en), 1);
        @(negedge clk);
        check("step_clk_en_after", 32'(o_dunit_clk_en), 0);
        wait_done("step", 5000);
        check("step_clk_en_cycles", 32'(clk_en_cnt), 1);

        // Run: halt rises after 10 pipeline cycles
        fill_random();
        push_dump();
        clk_en_cnt = 0;
        send_rx(8'h43);
        repeat (10) @(posedge clk);
        #1 i_halt = 1'b1;
        @(negedge clk);
        check("run_clk_en_at_halt", 32'(o_dunit_clk_en), 0);
        wait_done("run", 5000);
        check("run_clk_en_cycles", 32'(clk_en_cnt), 10);

        // 'C' with halt already high; rx bytes during the dump are ignored
        rpc0 = rpc_cnt;
        wr0  = wr_cnt;
        fill_random();
        push_dump();
        clk_en_cnt = 0;
        send_rx(8'h43);
        repeat (5) @(posedge clk);
        send_rx(8'h4C);
        send_rx(8'h53);
        send_rx(8'h00);
        send_rx(8'h52);
        wait_done("halted_run", 5000);
        check("halted_clk_en_cycles", 32'(clk_en_cnt), 0);
        check("halted_rx_ignored_rpc", 32'(rpc_cnt - rpc0), 0);
        @(posedge clk); #1 i_halt = 1'b0;
        send_rx(8'h00);
        repeat (3) @(negedge clk);
        check("unknown_cmd_state", 32'(o_state), 0);
        check("unknown_cmd_no_write", 32'(wr_cnt - wr0), 0);

        // Random load terminated by the halt word
        n = $urandom_range(3, 8);
        words.delete();
        for (int i = 0; i < n; i++) begin
            do w = $urandom; while (w == 32'hFFFF_FFFF);
            words.push_back(w);
        end
        words.push_back(32'hFFFF_FFFF);
        foreach (words[i]) exp_wr.push_back('{32'(i * 4), words[i]});
        send_rx(8'h4C);
        foreach (words[i]) send_word(words[i]);
        wait_done("rand_load", 2000);

        // Random steps
        for (int t = 0; t < 2; t++) begin
            fill_random();
            push_dump();
            clk_en_cnt = 0;
            send_rx(8'h53);
            wait_done("rand_step", 5000);
            check("rand_step_clk_en_cycles", 32'(clk_en_cnt), 1);
        end

        // Capacity: 130 words, only the first 128 are written
        wr0  = wr_cnt;
        rpc0 = rpc_cnt;
        words.delete();
        for (int i = 0; i < 130; i++) words.push_back(cmd_free_word());
        for (int i = 0; i < 128; i++) exp_wr.push_back('{32'(i * 4), words[i]});
        send_rx(8'h4C);
        foreach (words[i]) send_word(words[i]);
        wait_done("capacity", 3000);
        check("capacity_write_count", 32'(wr_cnt - wr0), 128);
        check("capacity_rpc_pulses", 32'(rpc_cnt - rpc0), 1);

        // Reset in the middle of a dump
        fill_random();
        push_dump();
        send_rx(8'h53);
        n = 0;
        while (exp_tx.size() > 236 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_dump_reached", 32'(n < 1000), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid_reset_tx_start", 32'(o_tx_start), 0);
        check("mid_reset_tx_data", 32'(o_tx_data), 0);
        check("mid_reset_clk_en", 32'(o_dunit_clk_en), 0);
        check("mid_reset_reset_pc", 32'(o_dunit_reset_pc), 0);
        check("mid_reset_w_mem", 32'(o_dunit_w_mem), 0);
        check("mid_reset_addr", 32'(o_dunit_addr), 0);
        check("mid_reset_addr_data", 32'(o_dunit_addr_data), 0);
        check("mid_reset_state", 32'(o_state), 0);
        exp_tx.delete();
        tx0 = tx_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_state", 32'(o_state), 0);
        check("post_reset_no_tx", 32'(tx_cnt - tx0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
